instruction_fetch_pipe: RTL and testbench

Parametrised, latency-tolerant instruction fetch stage: keeps its own fetch PC and issues one word-addressed read per cycle to a synchronous instruction memory with 1-cycle read latency. Returned words are queued in a DEPTH-entry prefetch FIFO and presented to decode through a valid/ready handshake. Branch/jump redirects squash in-flight and queued words. Sits between the instruction memory macro and the decode stage.

---
 rtl/instruction_fetch_pipe_if.sv | 39 +++
 rtl/instruction_fetch_pipe.sv | 117 +++++++++++
 tb/tb_instruction_fetch_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pipe_if.sv
// ============================================================================
// Module   : instruction_fetch_pipe_if
// Brief    : Instruction-memory bus plus decode handshake for the fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_pipe_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) ();
  logic [DATA_W-1:0] im_dataout;
  logic              im_cen;
  logic              im_wen;
  logic              im_oen;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_datain;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              id_ready;
  logic              if_valid;
  logic [DATA_W-1:0] instruction;
  logic [PC_W-1:0]   pc_min_one;

  modport master (
    input  im_dataout, redirect_valid, redirect_pc, id_ready,
    output im_cen, im_wen, im_oen, im_addr, im_datain,
           if_valid, instruction, pc_min_one
  );

  modport slave (
    output im_dataout, redirect_valid, redirect_pc, id_ready,
    input  im_cen, im_wen, im_oen, im_addr, im_datain,
           if_valid, instruction, pc_min_one
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_pipe.sv
// ============================================================================
// Module   : instruction_fetch_pipe
// Brief    : PC-driven fetch stage with 1-cycle memory and a prefetch FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_pipe #(
  parameter int          ADDR_W   = 11,
  parameter int          DATA_W   = 32,
  parameter int          PC_W     = 32,
  parameter int          DEPTH    = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  instruction_fetch_pipe_if.master    bus
);
  localparam int              c_PTR_W    = $clog2(DEPTH);
  localparam int              c_CNT_W    = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W:0] c_DEPTH   = (c_CNT_W + 1)'(DEPTH);
  localparam logic [PC_W-1:0] c_RESET_PC = PC_W'(RESET_PC);

  logic [PC_W-1:0]    r_fetch_pc;
  logic               r_inflight;
  logic [PC_W-1:0]    r_inflight_pc;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [DATA_W-1:0]  r_mem_ins [DEPTH];
  logic [PC_W-1:0]    r_mem_pc1 [DEPTH];

  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic [c_CNT_W:0]   w_occ;
  logic [ADDR_W-1:0]  w_fetch_addr;
  logic [ADDR_W-1:0]  w_redir_addr;

  generate
    if (PC_W >= ADDR_W) begin : g_addr_trunc
      assign w_fetch_addr = r_fetch_pc[ADDR_W-1:0];
      assign w_redir_addr = bus.redirect_pc[ADDR_W-1:0];
    end else begin : g_addr_ext
      assign w_fetch_addr = {{(ADDR_W - PC_W){1'b0}}, r_fetch_pc};
      assign w_redir_addr = {{(ADDR_W - PC_W){1'b0}}, bus.redirect_pc};
    end
  endgenerate

  assign w_valid = rst_n & (r_count != '0);
  assign w_pop   = w_valid & bus.id_ready & ~bus.redirect_valid;
  assign w_push  = r_inflight & ~bus.redirect_valid;
  assign w_occ   = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};
  // Slot reservation: an issue is allowed only if its return word is guaranteed room.
  assign w_issue = w_occ < (c_DEPTH + {{c_CNT_W{1'b0}}, w_pop});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= c_RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc    <= bus.redirect_pc + PC_W'(1);
      r_inflight    <= 1'b1;
      r_inflight_pc <= bus.redirect_pc;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + PC_W'(1);
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= r_count + {{(c_CNT_W - 1){1'b0}}, w_push}
                         - {{(c_CNT_W - 1){1'b0}}, w_pop};
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem_ins[r_wr_ptr] <= bus.im_dataout;
      r_mem_pc1[r_wr_ptr] <= r_inflight_pc + PC_W'(1);
    end
  end

  always_comb begin
    bus.im_cen  = 1'b1;
    bus.im_addr = '0;
    if (rst_n) begin
      if (bus.redirect_valid) begin
        bus.im_cen  = 1'b0;
        bus.im_addr = w_redir_addr;
      end else begin
        bus.im_cen  = ~w_issue;
        bus.im_addr = w_fetch_addr;
      end
    end
  end

  assign bus.im_wen      = 1'b1;
  assign bus.im_oen      = 1'b0;
  assign bus.im_datain   = '0;
  assign bus.if_valid    = w_valid;
  assign bus.instruction = w_valid ? r_mem_ins[r_rd_ptr] : '0;
  assign bus.pc_min_one  = w_valid ? r_mem_pc1[r_rd_ptr] : '0;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_pipe.sv
// ============================================================================
// Module   : tb_instruction_fetch_pipe
// Brief    : Directed plus random bench against a queue-based fetch model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_pipe;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int PC_W   = 8;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_fetch_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  instruction_fetch_pipe #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always @(posedge clk)
    if (bus.im_cen === 1'b0) bus.im_dataout <= mem[bus.im_addr];

  typedef struct {
    logic [DATA_W-1:0] ins;
    logic [PC_W-1:0]   pc1;
  } ent_t;

  ent_t            q[$];
  bit              pend;
  logic [PC_W-1:0] pend_pc;
  logic [PC_W-1:0] fpc;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare, then advance the model past the edge.
  task automatic step(input bit r, input bit rv, input logic [PC_W-1:0] rp, input bit rdy);
    bit                e_valid, e_cen, pop, issue;
    logic [DATA_W-1:0] e_ins;
    logic [PC_W-1:0]   e_pc1;
    logic [ADDR_W-1:0] e_addr;
    ent_t              e;
    @(negedge clk);
    rst_n              = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.id_ready       = rdy;
    #1;
    e_valid = 0; e_ins = '0; e_pc1 = '0; e_cen = 1; e_addr = '0; pop = 0; issue = 0;
    if (r) begin
      e_valid = (q.size() != 0);
      if (e_valid) begin
        e_ins = q[0].ins;
        e_pc1 = q[0].pc1;
      end
      pop = e_valid && rdy && !rv;
      if (rv) begin
        e_cen  = 0;
        e_addr = ADDR_W'(rp);
      end else begin
        issue  = (q.size() + int'(pend) - int'(pop)) < DEPTH;
        e_cen  = !issue;
        e_addr = ADDR_W'(fpc);
      end
    end
    check("if_valid",    32'(bus.if_valid),    32'(e_valid));
    check("instruction", bus.instruction,      e_ins);
    check("pc_min_one",  32'(bus.pc_min_one),  32'(e_pc1));
    check("im_cen",      32'(bus.im_cen),      32'(e_cen));
    check("im_addr",     32'(bus.im_addr),     32'(e_addr));
    check("im_wen",      32'(bus.im_wen),      32'd1);
    check("im_oen",      32'(bus.im_oen),      32'd0);
    check("im_datain",   bus.im_datain,        32'd0);
    if (!r) begin
      q.delete();
      pend = 0;
      fpc  = '0;
    end else if (rv) begin
      q.delete();
      pend    = 1;
      pend_pc = rp;
      fpc     = rp + PC_W'(1);
    end else begin
      if (pop) void'(q.pop_front());
      if (pend) begin
        e.ins = mem[ADDR_W'(pend_pc)];
        e.pc1 = pend_pc + PC_W'(1);
        q.push_back(e);
      end
      pend = issue;
      if (issue) begin
        pend_pc = fpc;
        fpc     = fpc + PC_W'(1);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 2**ADDR_W; a++) mem[a] = 32'h1000 + a;
    rst_n = 0; bus.redirect_valid = 0; bus.redirect_pc = '0; bus.id_ready = 0;
    pend = 0; fpc = '0; pend_pc = '0;

    repeat (3) step(0, 0, 8'h00, 1);
    repeat (10) step(1, 0, 8'h00, 1);

    // Backpressure from cycle 2 with a fresh start
    step(0, 0, 8'h00, 1);
    repeat (2) step(1, 0, 8'h00, 1);
    repeat (5) step(1, 0, 8'h00, 0);
    repeat (6) step(1, 0, 8'h00, 1);

    step(1, 1, 8'h40, 1);
    repeat (4) step(1, 0, 8'h00, 1);

    // Redirect with a full FIFO and decode stalled
    repeat (4) step(1, 0, 8'h00, 0);
    step(1, 1, 8'h80, 0);
    repeat (3) step(1, 0, 8'h00, 0);
    repeat (3) step(1, 0, 8'h00, 1);

    step(1, 1, 8'hFF, 1);
    repeat (5) step(1, 0, 8'h00, 1);

    step(1, 1, 8'h10, 1);
    step(1, 1, 8'h20, 1);
    repeat (4) step(1, 0, 8'h00, 1);

    repeat (2) step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    repeat (5) step(1, 0, 8'h00, 1);

    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 19) == 0),
           PC_W'($urandom),
           ($urandom_range(0, 9) < 6));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
